// File: rtl/vga_frame_scanout.sv
// 640x480@60 raster scanout: board-cell lookup, RGB444 and syncs 2 pixel_en ticks after the counters; stalls whenever pixel_en=0.
// VGA_new_frame_ready tracks vblank with no pipeline delay. Optional grid lines on empty cells: define GRID_LINES_EN.
module vga_frame_scanout #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CELL_PX   = 16,
  parameter int GRID_X0   = 240,
  parameter int GRID_Y0   = 80,
  parameter int GRID_COLS = 10,
  parameter int GRID_ROWS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pixel_en,
  output logic [3:0]  cell_col,
  output logic [4:0]  cell_row,
  output logic        cell_valid,
  input  logic [3:0]  cell_code,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        VGA_new_frame_ready
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CB      = $clog2(CELL_PX);
  localparam int GX1     = GRID_X0 + GRID_COLS * CELL_PX;
  localparam int GY1     = GRID_Y0 + GRID_ROWS * CELL_PX;

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;

  always_comb begin
    h_nxt = h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_nxt = '0;
      v_nxt = (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end
  end

  // Ready is computed from the next count so it changes on the same tick as v_cnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt               <= '0;
      v_cnt               <= '0;
      VGA_new_frame_ready <= 1'b0;
    end else if (pixel_en) begin
      h_cnt               <= h_nxt;
      v_cnt               <= v_nxt;
      VGA_new_frame_ready <= (v_nxt >= VW'(V_ACTIVE));
    end
  end

  int   x, y;
  logic active, in_board, border, hs_term, vs_term;

  assign x        = int'(h_cnt);
  assign y        = int'(v_cnt);
  assign active   = (x < H_ACTIVE) && (y < V_ACTIVE);
  assign in_board = active && (x >= GRID_X0) && (x < GX1) && (y >= GRID_Y0) && (y < GY1);
  assign border   = active && !in_board && (x >= GRID_X0 - 1) && (x <= GX1)
                    && (y >= GRID_Y0 - 1) && (y <= GY1);
  assign hs_term  = !((x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC));
  assign vs_term  = !((y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC));

  assign cell_valid = in_board;
  assign cell_col   = in_board ? 4'((x - GRID_X0) >> CB) : '0;
  assign cell_row   = in_board ? 5'((y - GRID_Y0) >> CB) : '0;

  logic       s1_active, s1_valid, s1_border, s1_hs, s1_vs;
  logic [3:0] s1_code;
`ifdef GRID_LINES_EN
  logic       on_line, s1_line;
  assign on_line = (((x - GRID_X0) & (CELL_PX - 1)) == 0) || (((y - GRID_Y0) & (CELL_PX - 1)) == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_active <= 1'b0;
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_code   <= '0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
`ifdef GRID_LINES_EN
      s1_line   <= 1'b0;
`endif
    end else if (pixel_en) begin
      s1_active <= active;
      s1_valid  <= in_board;
      s1_border <= border;
      s1_code   <= cell_code;
      s1_hs     <= hs_term;
      s1_vs     <= vs_term;
`ifdef GRID_LINES_EN
      s1_line   <= on_line;
`endif
    end
  end

  // cell_code is only trusted when the pixel was inside the board.
  logic [11:0] rgb_nxt;
  always_comb begin
    rgb_nxt = 12'h000;
    if (s1_active) begin
      if (s1_border) begin
        rgb_nxt = 12'h888;
      end else if (s1_valid) begin
        case (s1_code)
          4'd0:    rgb_nxt = 12'h000;
          4'd1:    rgb_nxt = 12'h0FF;
          4'd2:    rgb_nxt = 12'hFF0;
          4'd3:    rgb_nxt = 12'hF0F;
          4'd4:    rgb_nxt = 12'h0F0;
          4'd5:    rgb_nxt = 12'hF00;
          4'd6:    rgb_nxt = 12'h00F;
          4'd7:    rgb_nxt = 12'hF80;
          default: rgb_nxt = 12'hFFF;
        endcase
`ifdef GRID_LINES_EN
        if (s1_code == 4'd0 && s1_line) rgb_nxt = 12'h222;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else if (pixel_en) begin
      hsync <= s1_hs;
      vsync <= s1_vs;
      rgb   <= rgb_nxt;
    end
  end

endmodule
